// File: rtl/vga_pkg.sv
// Shared constants for the VGA framebuffer and its controller.
package vga_pkg;

  localparam int VGA_ADDR_W      = 15;
  localparam int VGA_DATA_W      = 16;
  localparam int VGA_DEPTH       = 32768;

  // Framebuffer layout seen by the VGA controller.
  localparam int FB_WORDS        = 4016;
  localparam int WORDS_PER_LINE  = 80;
  localparam int PIXEL_W         = 8;
  localparam int PIXELS_PER_WORD = 2;

  // Selects one 8-bit pixel out of a framebuffer word: sel=0 -> [7:0], sel=1 -> [15:8].
  function automatic logic [PIXEL_W-1:0] fb_pixel(input logic [VGA_DATA_W-1:0] word,
                                                  input logic                  sel);
    return sel ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/vga_dual_port_ram.sv
// True dual-port framebuffer RAM. Port A is the CPU side, port B the pixel
// fetch side. One shared clock, one-cycle registered read on both ports,
// write-first on the same port, old data on the opposite port, and port A
// wins when both ports write the same word. Contents survive reset.
module vga_dual_port_ram
  import vga_pkg::*;
#(
  parameter int ADDR_W = VGA_ADDR_W,
  parameter int DATA_W = VGA_DATA_W,
  parameter int DEPTH  = VGA_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic              wren_a,
  input  logic              wren_b,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Zero image loaded at configuration; reset never touches it.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] q_a_q = '0;
  logic [DATA_W-1:0] q_b_q = '0;
  logic [DATA_W-1:0] q_a_d;
  logic [DATA_W-1:0] q_b_d;

  logic              a_ok;
  logic              b_ok;
  logic [IDX_W-1:0]  idx_a;
  logic [IDX_W-1:0]  idx_b;

  assign idx_a = address_a[IDX_W-1:0];
  assign idx_b = address_b[IDX_W-1:0];

  // A fully populated address space needs no range check at all.
  if (DEPTH >= 2**ADDR_W) begin : g_full
    assign a_ok = 1'b1;
    assign b_ok = 1'b1;
  end else begin : g_part
    assign a_ok = (address_a < ADDR_W'(DEPTH));
    assign b_ok = (address_b < ADDR_W'(DEPTH));
  end

  // Next read data per port: zero in reset or out of range, own write data when writing, else stored word.
  always_comb begin
    q_a_d = '0;
    q_b_d = '0;
    if (!rst) begin
      if (a_ok) q_a_d = wren_a ? data_a : mem_q[idx_a];
      if (b_ok) q_b_d = wren_b ? data_b : mem_q[idx_b];
    end
  end

  // Array write; port A is issued last so it overrides B on a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wren_b && b_ok) mem_q[idx_b] <= data_b;
      if (wren_a && a_ok) mem_q[idx_a] <= data_a;
    end
  end

  // Registered read outputs, cleared while reset is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
    end
  end

  assign q_a = q_a_q;
  assign q_b = q_b_q;

endmodule

// File: tb/tb_vga_dual_port_ram.sv
module tb_vga_dual_port_ram;

  localparam int AW      = 15;
  localparam int DW      = 16;
  localparam int BIG_D   = 32768;
  localparam int SMALL_D = 4016;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] address_a = '0;
  logic [AW-1:0] address_b = '0;
  logic [DW-1:0] data_a = '0;
  logic [DW-1:0] data_b = '0;
  logic          wren_a = 1'b0;
  logic          wren_b = 1'b0;
  logic [DW-1:0] q_a, q_b, qs_a, qs_b;

  int checks   = 0;
  int failures = 0;

  // Reference images of both memories
  logic [DW-1:0] m_big   [BIG_D];
  logic [DW-1:0] m_small [SMALL_D];

  always #5 clk = ~clk;

  vga_dual_port_ram #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(BIG_D)) dut (
    .clk(clk), .rst(rst), .address_a(address_a), .address_b(address_b),
    .data_a(data_a), .data_b(data_b), .wren_a(wren_a), .wren_b(wren_b),
    .q_a(q_a), .q_b(q_b));

  vga_dual_port_ram #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(SMALL_D)) dut_s (
    .clk(clk), .rst(rst), .address_a(address_a), .address_b(address_b),
    .data_a(data_a), .data_b(data_b), .wren_a(wren_a), .wren_b(wren_b),
    .q_a(qs_a), .q_b(qs_b));

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read result for one port of a memory of the given depth.
  function automatic logic [DW-1:0] port_exp(input logic r, input int depth, input int addr,
                                             input logic we, input logic [DW-1:0] d,
                                             input logic [DW-1:0] stored);
    if (r || addr >= depth) return '0;
    return we ? d : stored;
  endfunction

  // One clock: drive inputs, predict outputs, check after the edge, then commit writes to the models.
  task automatic cycle(input logic r, input int aa, input int ab,
                       input logic [DW-1:0] da, input logic [DW-1:0] db,
                       input logic wa, input logic wb, input string tag);
    logic [DW-1:0] ea, eb, esa, esb, sa, sb;
    @(negedge clk);
    rst = r; address_a = AW'(aa); address_b = AW'(ab);
    data_a = da; data_b = db; wren_a = wa; wren_b = wb;
    sa  = (aa < SMALL_D) ? m_small[aa] : '0;
    sb  = (ab < SMALL_D) ? m_small[ab] : '0;
    ea  = port_exp(r, BIG_D,   aa, wa, da, m_big[aa]);
    eb  = port_exp(r, BIG_D,   ab, wb, db, m_big[ab]);
    esa = port_exp(r, SMALL_D, aa, wa, da, sa);
    esb = port_exp(r, SMALL_D, ab, wb, db, sb);
    @(posedge clk);
    #1;
    chk({tag, ".q_a"},  q_a,  ea);
    chk({tag, ".q_b"},  q_b,  eb);
    chk({tag, ".qs_a"}, qs_a, esa);
    chk({tag, ".qs_b"}, qs_b, esb);
    if (!r) begin
      if (wb) m_big[ab] = db;
      if (wa) m_big[aa] = da;
      if (wb && ab < SMALL_D) m_small[ab] = db;
      if (wa && aa < SMALL_D) m_small[aa] = da;
    end
    #3;
    chk({tag, ".hold_a"}, q_a, ea);
    chk({tag, ".hold_b"}, q_b, eb);
  endtask

  initial begin
    for (int i = 0; i < BIG_D; i++)   m_big[i]   = '0;
    for (int i = 0; i < SMALL_D; i++) m_small[i] = '0;

    #1;
    chk("pwrup.q_a", q_a, 16'h0000);
    chk("pwrup.q_b", q_b, 16'h0000);
    chk("pwrup.qs_a", qs_a, 16'h0000);
    chk("pwrup.qs_b", qs_b, 16'h0000);

    // Reset keeps memory and blocks writes
    cycle(0, 5, 0, 16'hBEEF, 16'h0, 1, 0, "preload");
    cycle(1, 5, 5, 16'h1111, 16'h0, 1, 0, "rst1");
    cycle(1, 5, 5, 16'h1111, 16'h0, 1, 0, "rst2");
    cycle(0, 5, 5, 16'h0, 16'h0, 0, 0, "rst_rel");
    chk("rst_keep_direct", q_b, 16'hBEEF);

    // Basic write A / read B
    cycle(0, 100, 0,   16'h1234, 16'h0, 1, 0, "wr100");
    chk("wr100_wfirst", q_a, 16'h1234);
    cycle(0, 0,   100, 16'h0,    16'h0, 0, 0, "rd100");
    chk("rd100_direct", q_b, 16'h1234);

    // Mixed-port collision returns old data on the reader
    cycle(0, 7, 0, 16'hAAAA, 16'h0, 1, 0, "pre7");
    cycle(0, 7, 7, 16'h5555, 16'h0, 1, 0, "coll7");
    chk("coll7_old", q_b, 16'hAAAA);
    cycle(0, 0, 7, 16'h0, 16'h0, 0, 0, "rd7");
    chk("rd7_new", q_b, 16'h5555);
    // Symmetric case: B writes, A reads
    cycle(0, 7, 7, 16'h0, 16'h6666, 0, 1, "coll7b");
    chk("coll7b_old", q_a, 16'h5555);
    cycle(0, 7, 0, 16'h0, 16'h0, 0, 0, "rd7b");

    // Dual write to the same address
    cycle(0, 9, 9, 16'h0001, 16'h0002, 1, 1, "dual9");
    chk("dual9_qb", q_b, 16'h0002);
    cycle(0, 9, 9, 16'h0, 16'h0, 0, 0, "rd9");
    chk("rd9_awins", q_b, 16'h0001);

    // Boundaries
    cycle(0, 0, 32767, 16'hA5A5, 16'h5A5A, 1, 1, "wr_edges");
    cycle(0, 32767, 0, 16'h0, 16'h0, 0, 0, "rd_edges");
    chk("rd_top", q_a, 16'h5A5A);
    cycle(0, 4016, 4015, 16'h7777, 16'h3C3C, 1, 1, "wr_small_edge");
    cycle(0, 4015, 4016, 16'h0, 16'h0, 0, 0, "rd_small_edge");
    chk("small_oor", qs_b, 16'h0000);
    chk("small_last", qs_a, 16'h3C3C);
    chk("big_4016", q_b, 16'h7777);

    // Streaming sweep on B with random CPU writes on A
    for (int i = 0; i < SMALL_D; i++)
      cycle(0, int'($urandom_range(0, 4095)), i, DW'($urandom), 16'h0,
            1'($urandom_range(0, 1)), 0, "stream");

    // Random traffic on both ports over a tight window to force collisions
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 15) == 0),
            int'($urandom_range(4008, 4023)), int'($urandom_range(4008, 4023)),
            DW'($urandom), DW'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_dual_port_ram.md
Name: vga_dual_port_ram

Overview:
- Synchronous true dual-port RAM used as the VGA framebuffer.
- Port A is the CPU write/read side; port B is the pixel-fetch read side driven by the VGA timing logic.
- Both ports share one clock and have registered outputs (one-cycle read latency).
- Memory contents are not cleared by reset, so the array maps onto block RAM.

Parameters:
- ADDR_W, 15, address width of each port.
- DATA_W, 16, word width.
- DEPTH, 32768, number of implemented words (must be ≤ 2**ADDR_W).

Ports:
- clk  input  1  rising-edge clock shared by both ports.
- rst  input  1  synchronous, active-high reset.
- address_a  input  ADDR_W  port A word address.
- address_b  input  ADDR_W  port B word address.
- data_a  input  DATA_W  port A write data.
- data_b  input  DATA_W  port B write data.
- wren_a  input  1  port A write enable.
- wren_b  input  1  port B write enable.
- q_a  output  DATA_W  port A registered read data.
- q_b  output  DATA_W  port B registered read data.

Behaviour:
- All state updates on the rising edge of clk. No asynchronous paths.
- Reset:
  - rst=1 at an edge forces q_a=0 and q_b=0 on that edge.
  - All writes on that edge are suppressed.
  - Memory array is unchanged.
  - Outputs stay 0 while rst is held.
  - The first edge with rst=0 performs a normal access.
- Power-up: array contents and q_a/q_b are 0 (initialised at configuration).
- Read:
  - q_x updates on the edge after address_x is presented (latency 1).
  - q_x holds its value between edges.
  - Reads occur every cycle; there is no read enable.
- Write: wren_x=1 at an edge writes data_x to mem[address_x] on that edge.
- Same-port read-during-write: write-first. When wren_x=1, q_x shows data_x on that same edge.
- Mixed-port read-during-write:
  - Port A writes address N while port B reads N on the same edge: q_b returns the old content of N.
  - The new value is visible on the following read.
  - Symmetric behaviour applies for a B write with an A read.
- Simultaneous writes to the same address on both ports: port A wins; mem[N]=data_a.
  - Each port's q follows its own write-first rule: q_a=data_a, q_b=data_b.
- Out-of-range addresses (address ≥ DEPTH, only possible when DEPTH < 2**ADDR_W):
  - Writes are ignored.
  - Reads return 0.
- Address 2**ADDR_W-1 is valid when DEPTH=2**ADDR_W. There is no wrap or auto-increment; addressing is purely combinational index.
- No handshake, no stalls; every cycle accepts one access per port.

Decomposition:
- Shared package vga_pkg:
  - VGA_ADDR_W=15, VGA_DATA_W=16, VGA_DEPTH=32768.
  - Framebuffer constants used by the VGA controller: FB_WORDS=4016, WORDS_PER_LINE=80, two 8-bit pixels per word (pixel0 in bits [7:0], pixel1 in bits [15:8]).
- No sub-module is natural. A single module holds the array, the two port processes and the collision/priority logic.

Test Plan:
- Reset: preload mem[5]=16'hBEEF, assert rst for 2 cycles with wren_a=1 addr 5 data 16'h1111 → q_a=q_b=0, mem[5] still 16'hBEEF (read after release returns 16'hBEEF one cycle later).
- Basic A-write/B-read: write A addr 100 = 16'h1234; next cycle B reads 100 → q_b=16'h1234 one cycle after address applied; q_a on the write edge = 16'h1234 (write-first).
- Mixed-port collision: mem[7]=16'hAAAA; same edge A writes 7 = 16'h5555 and B reads 7 → q_b=16'hAAAA; next edge B reads 7 → q_b=16'h5555.
- Dual write collision: A writes 9 = 16'h0001 and B writes 9 = 16'h0002 on the same edge → q_a=16'h0001, q_b=16'h0002; subsequent read of 9 on either port = 16'h0001.
- Boundaries: write/read addr 0 and addr 32767 with distinct patterns → both read back correctly. With DEPTH=4016, a write to addr 4016 is ignored and reading it returns 0.
- Streaming: B sweeps addresses 0..4015 consecutively while A writes random locations → each q_b equals the expected memory image with exactly one-cycle latency, with no gaps or stalls.
